// File: rtl/demux3_buf.sv
// demux3_buf: registered 1-to-3 steering buffer.
// One word per cycle enters on a valid/ready port. in_sel chooses which of three
// independent output FIFOs receives it. A stalled consumer blocks only the words
// addressed to its own channel.
// Build option: define DEMUX3_DEPTH2_EN to give each channel two entries instead of one.
// If LENGTH is not defined elsewhere, the data width defaults to 32 bits.

`ifndef LENGTH
`define LENGTH 32
`endif

module demux3_buf #(
    parameter int LEN = `LENGTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] in_data,
    input  logic [1:0]     in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [LEN-1:0] out1_data,
    output logic [LEN-1:0] out2_data,
    output logic [LEN-1:0] out3_data,
    output logic           out1_valid,
    output logic           out2_valid,
    output logic           out3_valid,
    input  logic           out1_ready,
    input  logic           out2_ready,
    input  logic           out3_ready
);

    logic [2:0]     sel_oh_s;     // one-hot destination channel
    logic [2:0]     full_s;       // channel holds D words
    logic [2:0]     valid_s;      // channel holds at least one word
    logic [2:0]     out_ready_s;  // consumer ready, channel-indexed
    logic [2:0]     push_s;       // word written into channel this edge
    logic [2:0]     pop_s;        // head removed from channel this edge
    logic           accept_s;
    logic [LEN-1:0] head_s [3];

    assign out_ready_s = {out3_ready, out2_ready, out1_ready};

    // Decode in_sel into a one-hot channel select. Codes 10 and 11 both go to ch3.
    always_comb begin
        sel_oh_s = 3'b000;
        case (in_sel)
            2'b00:   sel_oh_s = 3'b001;
            2'b01:   sel_oh_s = 3'b010;
            2'b10:   sel_oh_s = 3'b100;
            2'b11:   sel_oh_s = 3'b100;
            default: sel_oh_s = 3'b100;
        endcase
    end

    // Ready looks only at the selected channel: it has room, or it drains on this edge.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            in_ready = |(sel_oh_s & (~full_s | out_ready_s));
        end
    end

    assign accept_s = in_valid & in_ready;
    assign push_s   = sel_oh_s & {3{accept_s}};
    assign pop_s    = valid_s & out_ready_s;

    for (genvar k = 0; k < 3; k++) begin : g_ch
`ifdef DEMUX3_DEPTH2_EN
        logic [LEN-1:0] mem_r [2];
        logic           rd_ptr_r;
        logic           wr_ptr_r;
        logic [1:0]     cnt_r;

        // Two-entry circular buffer. Both pointers toggle, so they wrap from 1 back to 0.
        // When the channel is full and a push and a pop land on the same edge, the write
        // slot is the slot being drained.
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_r[0] <= {LEN{1'b0}};
                mem_r[1] <= {LEN{1'b0}};
                rd_ptr_r <= 1'b0;
                wr_ptr_r <= 1'b0;
                cnt_r    <= 2'd0;
            end else begin
                if (push_s[k]) begin
                    mem_r[wr_ptr_r] <= in_data;
                    wr_ptr_r        <= ~wr_ptr_r;
                end
                if (pop_s[k]) begin
                    rd_ptr_r <= ~rd_ptr_r;
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   cnt_r <= cnt_r + 2'd1;
                    2'b01:   cnt_r <= cnt_r - 2'd1;
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        assign full_s[k]  = (cnt_r == 2'd2);
        assign valid_s[k] = (cnt_r != 2'd0);
        assign head_s[k]  = mem_r[rd_ptr_r];
`else
        logic [LEN-1:0] data_r;
        logic           valid_r;

        // Single holding register. A full channel refills only on an edge where it also drains.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_r  <= {LEN{1'b0}};
                valid_r <= 1'b0;
            end else begin
                if (push_s[k]) begin
                    data_r <= in_data;
                end
                valid_r <= push_s[k] | (valid_r & ~pop_s[k]);
            end
        end

        assign full_s[k]  = valid_r;
        assign valid_s[k] = valid_r;
        assign head_s[k]  = data_r;
`endif
    end

    assign out1_data  = head_s[0];
    assign out2_data  = head_s[1];
    assign out3_data  = head_s[2];
    assign out1_valid = valid_s[0];
    assign out2_valid = valid_s[1];
    assign out3_valid = valid_s[2];

endmodule

// File: tb/tb_demux3_buf.sv
// Self-checking bench for demux3_buf.
// The reference model keeps one queue of words per channel.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_demux3_buf;

`ifdef DEMUX3_DEPTH2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [31:0] o1, o2, o3;
    logic        v1, v2, v3;
    logic        r1, r2, r3;

    always #5 clk = ~clk;

    demux3_buf #(.LEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1_data (o1),
        .out2_data (o2),
        .out3_data (o3),
        .out1_valid(v1),
        .out2_valid(v2),
        .out3_valid(v3),
        .out1_ready(r1),
        .out2_ready(r2),
        .out3_ready(r3)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q [3][$];
    bit          after_rst = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dest(input logic [1:0] s);
        if (s == 2'b00) return 0;
        if (s == 2'b01) return 1;
        return 2;
    endfunction

    // Runs one clock cycle: drive the inputs, compare the DUT with the model, then advance the model.
    task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic [2:0] rdy, output bit acc);
        logic [31:0] od [3];
        logic        ov [3];
        bit          exp_rdy;
        int          t;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; in_data = d;
        {r3, r2, r1} = rdy;
        #1;
        od = '{o1, o2, o3};
        ov = '{v1, v2, v3};
        t = dest(s);
        exp_rdy = !r && ((q[t].size() < D) || rdy[t]);
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("out%0d_valid", k + 1), {31'd0, ov[k]}, {31'd0, q[k].size() != 0});
            if (q[k].size() != 0)
                check_eq($sformatf("out%0d_data", k + 1), od[k], q[k][0]);
            else if (after_rst)
                check_eq($sformatf("out%0d_data_rst", k + 1), od[k], 32'd0);
        end
        acc = v && exp_rdy && !r;
        if (r) begin
            for (int k = 0; k < 3; k++) q[k].delete();
            after_rst = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++)
                if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
            if (acc) q[t].push_back(d);
            after_rst = 1'b0;
        end
    endtask

    initial begin
        bit          acc;
        bit          pat [6];
        int          i;
        int          cyc;
        logic [31:0] words [4];
        logic [1:0]  sels [4];

        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = 32'd0;
        r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // Reset held for 3 cycles while a word is offered to ch1.
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 2'b00, 32'hDEAD_0000 + c, 3'b111, acc);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        // Routing: four consecutive words, one per select code.
        words = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        sels  = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, sels[c], words[c], 3'b111, acc);
            check_eq("route_acc", {31'd0, acc}, 32'd1);
        end
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        // Isolation: ch2 fills while its consumer is stalled; ch1 traffic still flows.
        for (int c = 0; c < D; c++) cycle(1'b0, 1'b1, 2'b01, 32'h200 + c, 3'b101, acc);
        cycle(1'b0, 1'b1, 2'b01, 32'h2FF, 3'b101, acc);
        check_eq("iso_blocked", {31'd0, acc}, 32'd0);
        cycle(1'b0, 1'b1, 2'b00, 32'h11, 3'b101, acc);
        check_eq("iso_ch1_acc", {31'd0, acc}, 32'd1);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b101, acc);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        // Full ch1 accepts a new word on the edge where it drains.
        for (int c = 0; c < D; c++) cycle(1'b0, 1'b1, 2'b00, 32'h100 + c, 3'b110, acc);
        cycle(1'b0, 1'b1, 2'b00, 32'h55, 3'b111, acc);
        check_eq("full_drain_acc", {31'd0, acc}, 32'd1);
        check_eq("full_drain_cnt", q[0].size(), D);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        // Push 1..6 to ch3 while out3_ready follows the pattern 1 0 1 1 0 1.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        i = 0; cyc = 0;
        while (i < 6 && cyc < 30) begin
            cycle(1'b0, 1'b1, 2'b10, i + 1, {pat[cyc % 6], 2'b11}, acc);
            if (acc) i++;
            cyc++;
        end
        check_eq("wrap_sent", i, 6);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        // Reset during an accept and a drain, with every channel holding data.
        cycle(1'b0, 1'b1, 2'b00, 32'h301, 3'b000, acc);
        cycle(1'b0, 1'b1, 2'b01, 32'h302, 3'b000, acc);
        cycle(1'b0, 1'b1, 2'b10, 32'h303, 3'b000, acc);
        cycle(1'b1, 1'b1, 2'b00, 32'h304, 3'b111, acc);
        cycle(1'b0, 1'b1, 2'b01, 32'h77, 3'b111, acc);
        check_eq("post_rst_acc", {31'd0, acc}, 32'd1);
        cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        // Random traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom), $urandom, 3'($urandom), acc);
        end
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 2'b00, 32'd0, 3'b111, acc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
